uart_tx_scheduler: RTL and testbench

- Shares the UART transmit path between two byte requesters (A: core store port, B: debug port) using round-robin arbitration.
- Buffers accepted bytes in a small FIFO and drives the UART load/tx_start handshake, one byte at a time, until the UART reports the byte transmitted.
- Owns the UART baud-divisor configuration register; the register can change only while the transmit path is quiescent.
- Sits between the bus-side requesters and the uart top level, in the system clock domain.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_byte_fifo.sv | 85 ++++++++
 rtl/uart_tx_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit scheduler.
//   byte_t               : one UART payload byte
//   state_e              : transmit FSM states (IDLE, XFER, RECOVER)
//   UART_DEFAULT_DIVISOR : baud divisor loaded at reset
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        RECOVER = 2'd2
    } state_e;

    localparam logic [31:0] UART_DEFAULT_DIVISOR = 32'd5208;

endpackage : uart_pkg

// File: rtl/uart_byte_fifo.sv
// -----------------------------------------------------------------------------
// uart_byte_fifo
// Synchronous byte FIFO, registered storage, no write-to-read bypass.
// A push while full or a pop while empty is ignored. A push and a pop in the
// same cycle leave the occupancy unchanged.
//
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   push, push_data  : enqueue request and byte
//   pop              : dequeue request (head advances at the clock edge)
//   pop_data         : current head byte (valid while !empty)
//   full, empty      : occupancy flags
//   count            : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  byte_t                    push_data,
    input  logic                     pop,
    output byte_t                    pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    byte_t            mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    assign do_push = push & ~full;
    assign do_pop  = pop  & ~empty;

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so the pointers wrap on their own.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is not reset; the pointers and count define which
    // entries are meaningful, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule : uart_byte_fifo

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter between two byte requesters (A: core store port,
// B: debug port) with round-robin arbitration, buffers accepted bytes in a
// FIFO, and runs the UART load/start handshake one byte at a time. Also owns
// the UART baud divisor register, writable only while the path is quiescent.
//
// Ports:
//   clk, reset                    : system clock, asynchronous active-low reset
//   a_valid/a_data/a_ready        : requester A byte handshake
//   b_valid/b_data/b_ready        : requester B byte handshake
//   cfg_we/cfg_divisor/cfg_ack    : divisor write request, ack pulse when applied
//   uart_in                       : byte presented to the UART
//   uart_load, uart_tx_start      : UART strobes, high for the whole transfer
//   uart_data_transmitted         : UART done flag (asynchronous to clk)
//   uart_baud_divisor             : divisor driven to the UART
//   busy                          : FIFO non-empty or FSM not idle
//   timeout_err                   : sticky, set when a transfer is abandoned
//   tx_count                      : bytes completed, wrapping 16-bit counter
//   fifo_count                    : current FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH      = 8,
    parameter int          TIMEOUT_CYCLES  = 2000000,
    parameter logic [31:0] DEFAULT_DIVISOR = UART_DEFAULT_DIVISOR
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          a_valid,
    input  logic [7:0]                    a_data,
    output logic                          a_ready,
    input  logic                          b_valid,
    input  logic [7:0]                    b_data,
    output logic                          b_ready,
    input  logic                          cfg_we,
    input  logic [31:0]                   cfg_divisor,
    output logic                          cfg_ack,
    output logic [7:0]                    uart_in,
    output logic                          uart_load,
    output logic                          uart_tx_start,
    input  logic                          uart_data_transmitted,
    output logic [31:0]                   uart_baud_divisor,
    output logic                          busy,
    output logic                          timeout_err,
    output logic [15:0]                   tx_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // Wide enough to hold TIMEOUT_CYCLES, so the increment on the final
    // transfer cycle cannot wrap.
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e         state_q,       state_d;
    byte_t          byte_q,        byte_d;
    logic [TW-1:0]  tmo_q,         tmo_d;
    logic [15:0]    tx_count_q,    tx_count_d;
    logic           timeout_err_q, timeout_err_d;
    logic [31:0]    divisor_q,     divisor_d;
    logic           cfg_ack_q,     cfg_ack_d;
    logic           prio_q,        prio_d;    // 0: A holds priority, 1: B
    logic [2:0]     sync_q,        sync_d;    // [0],[1] synchronizer, [2] edge history

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic   fifo_push;
    logic   fifo_pop;
    logic   fifo_full;
    logic   fifo_empty;
    byte_t  push_byte;
    byte_t  fifo_head;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_byte),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Done-flag synchronizer: two flops into clk, a third for rise detect.
    // ------------------------------------------------------------------
    logic sync2;
    logic done_rise;

    assign sync_d    = {sync_q[1:0], uart_data_transmitted};
    assign sync2     = sync_q[1];
    assign done_rise = sync_q[1] & ~sync_q[2];

    // ------------------------------------------------------------------
    // Round-robin arbiter. Priority only flips when both requesters
    // contend and one of them is granted; an uncontended grant keeps it.
    // ------------------------------------------------------------------
    logic grant_a;
    logic grant_b;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!fifo_full) begin
            if (a_valid && b_valid) begin
                grant_a = ~prio_q;
                grant_b =  prio_q;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign fifo_push = grant_a | grant_b;
    assign push_byte = grant_a ? a_data : b_data;
    assign prio_d    = (a_valid && b_valid && fifo_push) ? ~prio_q : prio_q;

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        byte_d        = byte_q;
        tmo_d         = tmo_q;
        tx_count_d    = tx_count_q;
        timeout_err_d = timeout_err_q;
        fifo_pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    byte_d   = fifo_head;
                    tmo_d    = '0;
                    state_d  = XFER;
                end
            end
            XFER: begin
                tmo_d = tmo_q + 1'b1;
                // A completion seen on the final cycle still counts as sent.
                if (done_rise) begin
                    tx_count_d = tx_count_q + 16'd1;
                    state_d    = RECOVER;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = RECOVER;
                end
            end
            RECOVER: begin
                // Wait for the UART to drop its done flag so the next byte
                // cannot see a stale level as a fresh completion.
                if (!sync2) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Divisor register: written only when nothing can be in flight or be
    // about to enter the FIFO in this cycle.
    // ------------------------------------------------------------------
    logic cfg_apply;

    assign cfg_apply = cfg_we && (state_q == IDLE) && fifo_empty && !grant_a && !grant_b;
    assign divisor_d = cfg_apply ? cfg_divisor : divisor_q;
    assign cfg_ack_d = cfg_apply;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            byte_q        <= '0;
            tmo_q         <= '0;
            tx_count_q    <= '0;
            timeout_err_q <= 1'b0;
            divisor_q     <= DEFAULT_DIVISOR;
            cfg_ack_q     <= 1'b0;
            prio_q        <= 1'b0;
            sync_q        <= '0;
        end else begin
            state_q       <= state_d;
            byte_q        <= byte_d;
            tmo_q         <= tmo_d;
            tx_count_q    <= tx_count_d;
            timeout_err_q <= timeout_err_d;
            divisor_q     <= divisor_d;
            cfg_ack_q     <= cfg_ack_d;
            prio_q        <= prio_d;
            sync_q        <= sync_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign uart_in           = byte_q;
    assign uart_load         = (state_q == XFER);
    assign uart_tx_start     = (state_q == XFER);
    assign uart_baud_divisor = divisor_q;
    assign cfg_ack           = cfg_ack_q;
    assign busy              = !fifo_empty || (state_q != IDLE);
    assign timeout_err       = timeout_err_q;
    assign tx_count          = tx_count_q;

endmodule : uart_tx_scheduler

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Self-checking bench for uart_tx_scheduler. A reference model of the
// arbiter/FIFO (priority bit, occupancy, queue of expected bytes) is stepped
// once per cycle and compared with the DUT; a behavioural UART raises its
// done flag a programmable number of cycles after load and counts the
// completions it granted.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int          DEPTH   = 8;
    localparam int          TMO     = 1000;
    localparam logic [31:0] DIV_RST = 32'd5208;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   a_valid, b_valid;
    logic [7:0]             a_data, b_data;
    logic                   a_ready, b_ready;
    logic                   cfg_we;
    logic [31:0]            cfg_divisor;
    logic                   cfg_ack;
    logic [7:0]             uart_in;
    logic                   uart_load, uart_tx_start;
    logic                   uart_data_transmitted;
    logic [31:0]            uart_baud_divisor;
    logic                   busy, timeout_err;
    logic [15:0]            tx_count;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0;
    int errors = 0;

    // UART model controls (written by the stimulus, read by the model)
    logic stall      = 1'b0;
    int   done_delay = 20;
    int   exp_done   = 0;     // completions the UART model has signalled

    // Arbiter/FIFO reference model state (stimulus process only)
    logic [7:0] exp_q[$];
    int         model_cnt = 0;
    logic       prio_b    = 1'b0;
    logic       load_prev = 1'b0;
    logic [7:0] held      = 8'h00;
    logic       last_a, last_b;
    int         last_cnt;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .FIFO_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES  (TMO),
        .DEFAULT_DIVISOR (DIV_RST)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .a_valid               (a_valid),
        .a_data                (a_data),
        .a_ready               (a_ready),
        .b_valid               (b_valid),
        .b_data                (b_data),
        .b_ready               (b_ready),
        .cfg_we                (cfg_we),
        .cfg_divisor           (cfg_divisor),
        .cfg_ack               (cfg_ack),
        .uart_in               (uart_in),
        .uart_load             (uart_load),
        .uart_tx_start         (uart_tx_start),
        .uart_data_transmitted (uart_data_transmitted),
        .uart_baud_divisor     (uart_baud_divisor),
        .busy                  (busy),
        .timeout_err           (timeout_err),
        .tx_count              (tx_count),
        .fifo_count            (fifo_count)
    );

    // Behavioural UART: done rises after done_delay cycles of load, is held
    // for four cycles, then drops. Driven 2 time units after the clock edge.
    initial begin : uart_model
        int cnt;
        int hold;
        cnt  = 0;
        hold = 0;
        uart_data_transmitted = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset) begin
                uart_data_transmitted = 1'b0;
                cnt      = 0;
                hold     = 0;
                exp_done = 0;
            end else if (uart_data_transmitted) begin
                hold++;
                if (hold >= 4) begin
                    uart_data_transmitted = 1'b0;
                    hold = 0;
                end
            end else if (uart_load && !stall) begin
                cnt++;
                if (cnt >= done_delay) begin
                    uart_data_transmitted = 1'b1;
                    cnt = 0;
                    exp_done++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference model, evaluated at the falling edge of each cycle.
    task automatic monitor();
        logic full, ga, gb;
        if (!reset) begin
            exp_q.delete();
            model_cnt = 0;
            prio_b    = 1'b0;
            load_prev = 1'b0;
            return;
        end
        // A transfer starting this cycle means the head was popped last cycle.
        if (uart_load && !load_prev) begin
            model_cnt--;
            check("byte_available", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                held = exp_q.pop_front();
                check("uart_in_order", 32'(uart_in), 32'(held));
            end
        end else if (uart_load) begin
            check("uart_in_stable", 32'(uart_in), 32'(held));
        end
        full = (model_cnt == DEPTH);
        ga = !full && a_valid && (!b_valid || !prio_b);
        gb = !full && b_valid && (!a_valid || prio_b);
        check("a_ready", 32'(a_ready), 32'(ga));
        check("b_ready", 32'(b_ready), 32'(gb));
        check("fifo_count", 32'(fifo_count), 32'(model_cnt));
        if (ga) exp_q.push_back(a_data);
        if (gb) exp_q.push_back(b_data);
        if (ga || gb) model_cnt++;
        if (a_valid && b_valid && (ga || gb)) prio_b = !prio_b;
        last_a    = a_ready;
        last_b    = b_ready;
        last_cnt  = int'(fifo_count);
        load_prev = uart_load;
    endtask

    // One clock cycle: model at the falling edge, return 1 unit after rising.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy && !uart_data_transmitted) break;
            step();
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin : stimulus
        int nb;
        int n;
        int prev;

        reset = 1'b0;
        a_valid = 1'b0; a_data = 8'h00;
        b_valid = 1'b0; b_data = 8'h00;
        cfg_we = 1'b0;  cfg_divisor = 32'd0;

        // ---------------- reset state ----------------
        step(); step();
        check("rst_uart_load",   32'(uart_load),     32'd0);
        check("rst_tx_start",    32'(uart_tx_start), 32'd0);
        check("rst_uart_in",     32'(uart_in),       32'd0);
        check("rst_fifo_count",  32'(fifo_count),    32'd0);
        check("rst_busy",        32'(busy),          32'd0);
        check("rst_tx_count",    32'(tx_count),      32'd0);
        check("rst_timeout_err", 32'(timeout_err),   32'd0);
        check("rst_cfg_ack",     32'(cfg_ack),       32'd0);
        check("rst_divisor",     uart_baud_divisor,  DIV_RST);
        reset = 1'b1;
        step(); step();

        // ---------------- single byte, latency ----------------
        done_delay = 500;
        a_valid = 1'b1; a_data = 8'h55;          // accept cycle N
        step();
        a_valid = 1'b0;                          // cycle N+1: pop
        check("lat_n1_load",  32'(uart_load),  32'd0);
        check("lat_n1_count", 32'(fifo_count), 32'd1);
        step();                                  // cycle N+2: XFER
        check("lat_n2_load",  32'(uart_load),     32'd1);
        check("lat_n2_start", 32'(uart_tx_start), 32'd1);
        check("lat_n2_data",  32'(uart_in),       32'h55);
        check("lat_n2_busy",  32'(busy),          32'd1);
        wait_idle(700);
        check("single_tx_count", 32'(tx_count),  32'd1);
        check("single_load_off", 32'(uart_load), 32'd0);

        // ---------------- contention, A holds priority ----------------
        done_delay = 10;
        a_valid = 1'b1; a_data = 8'hA1;
        b_valid = 1'b1; b_data = 8'hB1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("cont_a_grant", 32'(last_a), 32'(i % 2 == 0));
            check("cont_b_grant", 32'(last_b), 32'(i % 2 == 1));
        end
        a_valid = 1'b0; b_valid = 1'b0;
        wait_idle(500);
        check("cont_tx_count", 32'(tx_count), 32'd5);

        // ---------------- randomized traffic ----------------
        done_delay = int'($urandom_range(5, 40));
        for (int i = 0; i < 300; i++) begin
            a_valid = 1'($urandom_range(0, 1));
            b_valid = 1'($urandom_range(0, 1));
            a_data  = 8'($urandom);
            b_data  = 8'($urandom);
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        wait_idle(5000);
        check("rand_tx_count", 32'(tx_count), 32'(exp_done));

        // ---------------- full FIFO ----------------
        stall = 1'b1;
        done_delay = 20;
        nb = 0;
        b_valid = 1'b1; b_data = 8'hC0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (last_b) begin
                nb++;
                b_data = b_data + 8'd1;
            end
        end
        check("full_accepted", 32'(nb), 32'd9);
        check("full_count",    32'(fifo_count), 32'(DEPTH));
        stall = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (last_b) break;
        end
        check("full_retry_accepted", 32'(last_b),   32'd1);
        check("full_retry_count",    32'(last_cnt), 32'd7);
        b_valid = 1'b0;
        wait_idle(2000);
        check("full_tx_count", 32'(tx_count), 32'(exp_done));

        // ---------------- timeout ----------------
        prev  = int'(tx_count);
        stall = 1'b1;
        a_valid = 1'b1; a_data = 8'h77;
        step();
        a_data = 8'h78;
        step();
        a_valid = 1'b0;
        n = 0;
        for (int i = 0; i < TMO + 50; i++) begin
            if (!uart_load) break;
            n++;
            step();
        end
        check("tmo_xfer_cycles", 32'(n),           32'(TMO));
        check("tmo_err_set",     32'(timeout_err), 32'd1);
        check("tmo_tx_count",    32'(tx_count),    32'(prev));
        stall = 1'b0;
        wait_idle(500);
        check("tmo_next_byte_sent", 32'(tx_count),    32'(prev + 1));
        check("tmo_err_sticky",     32'(timeout_err), 32'd1);

        // ---------------- config write ----------------
        stall = 1'b1;
        a_valid = 1'b1; a_data = 8'h99;
        step();
        a_valid = 1'b0;
        step(); step();
        cfg_we = 1'b1; cfg_divisor = 32'd868;
        step();
        cfg_we = 1'b0;
        check("cfg_busy_no_ack",  32'(cfg_ack),        32'd0);
        check("cfg_busy_divisor", uart_baud_divisor,   DIV_RST);
        stall = 1'b0;
        wait_idle(500);
        cfg_we = 1'b1; a_valid = 1'b1; a_data = 8'h42;   // grant blocks write
        step();
        cfg_we = 1'b0; a_valid = 1'b0;
        check("cfg_grant_no_ack",  32'(cfg_ack),       32'd0);
        check("cfg_grant_divisor", uart_baud_divisor,  DIV_RST);
        wait_idle(500);
        cfg_we = 1'b1; cfg_divisor = 32'd868;
        step();
        check("cfg_idle_ack",     32'(cfg_ack),        32'd1);
        check("cfg_idle_divisor", uart_baud_divisor,   32'd868);
        cfg_divisor = 32'd0;
        step();
        check("cfg_zero_ack",     32'(cfg_ack),        32'd1);
        check("cfg_zero_divisor", uart_baud_divisor,   32'd0);
        cfg_divisor = 32'd868;
        step();
        cfg_we = 1'b0;
        step();
        check("cfg_ack_pulse_end", 32'(cfg_ack),       32'd0);
        check("cfg_final_divisor", uart_baud_divisor,  32'd868);

        // ---------------- reset mid-XFER ----------------
        stall = 1'b1;
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data = 8'hD0 + 8'(i);
            step();
        end
        a_valid = 1'b0;
        step();
        check("pre_rst_load",  32'(uart_load),  32'd1);
        check("pre_rst_count", 32'(fifo_count), 32'd3);
        reset = 1'b0;
        #1;
        check("mid_rst_load",        32'(uart_load),     32'd0);
        check("mid_rst_tx_start",    32'(uart_tx_start), 32'd0);
        check("mid_rst_uart_in",     32'(uart_in),       32'd0);
        check("mid_rst_fifo_count",  32'(fifo_count),    32'd0);
        check("mid_rst_busy",        32'(busy),          32'd0);
        check("mid_rst_tx_count",    32'(tx_count),      32'd0);
        check("mid_rst_timeout_err", 32'(timeout_err),   32'd0);
        check("mid_rst_divisor",     uart_baud_divisor,  DIV_RST);
        step(); step();
        reset = 1'b1;
        stall = 1'b0;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);
        a_valid = 1'b1; a_data = 8'hE5;
        step();
        a_valid = 1'b0;
        wait_idle(500);
        check("post_rst_tx_count", 32'(tx_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx_scheduler
